// File: rtl/bus_matrix.sv
// bus_matrix
//   Parametrised shared-bus interconnect between NUM_MASTERS bus masters
//   (CPU/DMA) and NUM_SLAVES slaves (ROM/GPIO/peripherals). It contains:
//     - a registered round-robin arbiter with seamless owner handover
//     - a combinational master-to-slave mux driven by the current owner
//     - an address decoder that turns the top SEL_W address bits into chip selects
//     - a read-return mux from the selected slave back to all masters
//     - a registered decode-error responder (and, optionally, a stall timeout)
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   : an access stalled by its slave for TIMEOUT cycles is aborted
//                 with a one-cycle error response.
//     undefined : no timeout; a stalled slave holds the bus indefinitely.
//
//   Ports
//     clk        in   system clock
//     reset_     in   asynchronous reset, active high
//     m_req_     in   per-master bus request, active low
//     m_grnt_    out  per-master grant, active low, registered
//     m_addr     in   flattened master word addresses (master i at [i*ADDR_W +: ADDR_W])
//     m_as_      in   per-master address strobe, active low
//     m_rw       in   per-master direction, 1 = read
//     m_wr_data  in   flattened master write data
//     m_rd_data  out  read data returned to all masters
//     m_rdy_     out  ready returned to all masters, active low
//     s_addr     out  shared slave address
//     s_as_      out  shared slave strobe, active low
//     s_rw       out  shared slave direction
//     s_wr_data  out  shared slave write data
//     s_cs_      out  per-slave chip select, active low
//     s_rd_data  in   flattened slave read data
//     s_rdy_     in   per-slave ready, active low
//     bus_err    out  one-cycle error pulse (decode error or timeout)
//
//   Arbiter states
//     state | meaning
//     IDLE  | no owner, bus outputs at idle values
//     OWNED | owner_q holds the bus while its request stays low
module bus_matrix #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 8,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [NUM_MASTERS-1:0]        m_req_,
  output logic [NUM_MASTERS-1:0]        m_grnt_,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as_,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [DATA_W-1:0]             m_rd_data,
  output logic                          m_rdy_,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic [NUM_SLAVES-1:0]         s_cs_,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_rd_data,
  input  logic [NUM_SLAVES-1:0]         s_rdy_,
  output logic                          bus_err
);

  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, OWNED} state_e;

  state_e                 state_q, state_d;
  logic [MIDX_W-1:0]      owner_q, owner_d;
  logic [MIDX_W-1:0]      ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
  logic                   err_q, err_d;

  logic [MIDX_W-1:0]      scan_idx, cand;
  logic                   found;

  logic                   owner_valid;
  logic [SEL_W-1:0]       slv_idx;
  logic                   idx_mapped;
  logic                   cs_valid;
  logic [DATA_W-1:0]      sel_data;
  logic                   sel_rdy_;
  logic                   dec_trig;
  logic                   to_hit;

  // ---------------------------------------------------------------- arbiter
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grnt_q  <= grnt_d;
      err_q   <= err_d;
    end
  end

  // Re-arbitrate only when idle or when the owner has dropped its request,
  // so the next grant lands on the same edge the old one is released.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    found    = 1'b0;
    cand     = '0;
    scan_idx = '0;
    if (state_q == IDLE || m_req_[owner_q]) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        scan_idx = MIDX_W'((int'(ptr_q) + j) % NUM_MASTERS);
        if (!found && !m_req_[scan_idx]) begin
          found = 1'b1;
          cand  = scan_idx;
        end
      end
      if (found) begin
        state_d = OWNED;
        owner_d = cand;
        ptr_d   = (cand == MIDX_W'(NUM_MASTERS - 1)) ? '0 : cand + 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
    grnt_d = '0;
    if (state_d == OWNED) grnt_d[owner_d] = 1'b1;
  end

  assign m_grnt_     = ~grnt_q;
  assign owner_valid = (state_q == OWNED);

  // ------------------------------------------------------------- master mux
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (owner_valid) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (owner_q == MIDX_W'(i)) begin
          s_addr    = m_addr[i*ADDR_W +: ADDR_W];
          s_as_     = m_as_[i];
          s_rw      = m_rw[i];
          s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // ---------------------------------------------------- decoder / read return
  assign slv_idx    = s_addr[ADDR_W-1 -: SEL_W];
  // Extra bit so NUM_SLAVES == 2**SEL_W compares correctly.
  assign idx_mapped = ({1'b0, slv_idx} < (SEL_W+1)'(NUM_SLAVES));
  assign cs_valid   = owner_valid && idx_mapped;

  // Chip select does not wait for the strobe; slaves qualify with s_as_.
  always_comb begin
    s_cs_    = '1;
    sel_data = '0;
    sel_rdy_ = 1'b1;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (cs_valid && slv_idx == SEL_W'(s)) begin
        s_cs_[s] = 1'b0;
        sel_data = s_rd_data[s*DATA_W +: DATA_W];
        sel_rdy_ = s_rdy_[s];
      end
    end
  end

  always_comb begin
    m_rd_data = sel_data;
    m_rdy_    = sel_rdy_;
    if (err_q) begin
      m_rd_data = '0;
      m_rdy_    = 1'b0;
    end
  end

  assign bus_err  = err_q;
  assign dec_trig = owner_valid && !s_as_ && !idx_mapped;

  // Blocking a pulse right after one gives error/idle/error on a held strobe,
  // and merges a coincident timeout and decode error into one pulse.
  assign err_d = (dec_trig || to_hit) && !err_q;

  // ---------------------------------------------------------- stall timeout
`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_chg;

  assign owner_chg = (state_d != state_q) || (owner_d != owner_q);
  assign to_hit    = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (to_hit || !m_rdy_ || s_as_ || owner_chg) begin
      cnt_d = '0;
    end else if (owner_valid && sel_rdy_) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_bus_matrix.sv
module tb_bus_matrix;

  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         reset_;
  logic [3:0]   m_req_, m_as_, m_rw;
  logic [29:0]  maddr [4];
  logic [31:0]  mwd   [4];
  logic [31:0]  sdata [8];
  logic [7:0]   srdy;

  logic [119:0] m_addr;
  logic [127:0] m_wr_data;
  logic [255:0] s_rd_data8;
  logic [191:0] s_rd_data6;

  logic [3:0]  g8, g6;
  logic [31:0] rd8, rd6, wd8, wd6;
  logic        rdy8, rdy6, as8, as6, rw8, rw6, be8, be6;
  logic [29:0] a8, a6;
  logic [7:0]  cs8;
  logic [5:0]  cs6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    m_addr     = '0;
    m_wr_data  = '0;
    s_rd_data8 = '0;
    s_rd_data6 = '0;
    for (int i = 0; i < 4; i++) begin
      m_addr[i*30 +: 30]    = maddr[i];
      m_wr_data[i*32 +: 32] = mwd[i];
    end
    for (int i = 0; i < 8; i++) s_rd_data8[i*32 +: 32] = sdata[i];
    for (int i = 0; i < 6; i++) s_rd_data6[i*32 +: 32] = sdata[i];
  end

  bus_matrix #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_(reset_), .m_req_(m_req_), .m_grnt_(g8), .m_addr(m_addr),
    .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(rd8), .m_rdy_(rdy8),
    .s_addr(a8), .s_as_(as8), .s_rw(rw8), .s_wr_data(wd8), .s_cs_(cs8),
    .s_rd_data(s_rd_data8), .s_rdy_(srdy), .bus_err(be8));

  bus_matrix #(.NUM_SLAVES(6), .TIMEOUT(TO)) dut6 (
    .clk(clk), .reset_(reset_), .m_req_(m_req_), .m_grnt_(g6), .m_addr(m_addr),
    .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data), .m_rd_data(rd6), .m_rdy_(rdy6),
    .s_addr(a6), .s_as_(as6), .s_rw(rw6), .s_wr_data(wd6), .s_cs_(cs6),
    .s_rd_data(s_rd_data6), .s_rdy_(srdy[5:0]), .bus_err(be6));

  // ---------------- behavioural model: k = 0 -> 8 slaves, k = 1 -> 6 slaves
  int own [2] = '{-1, -1};
  int ptr [2] = '{0, 0};
  bit err_m [2] = '{1'b0, 1'b0};
`ifdef BUS_TIMEOUT_EN
  int stall [2] = '{0, 0};
`endif

  function automatic int nsl(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic void exp_outs(input int k, output logic [3:0] g, output logic [29:0] a,
                                   output logic as_, output logic rw, output logic [31:0] wd,
                                   output logic [7:0] cs, output logic [31:0] rd,
                                   output logic rdy, output logic be);
    int idx;
    g = 4'hF; a = '0; as_ = 1'b1; rw = 1'b1; wd = '0; cs = 8'hFF; rd = '0; rdy = 1'b1; be = 1'b0;
    if (own[k] >= 0) begin
      g[2'(own[k])] = 1'b0;
      a   = maddr[2'(own[k])];
      as_ = m_as_[2'(own[k])];
      rw  = m_rw[2'(own[k])];
      wd  = mwd[2'(own[k])];
      idx = int'(a[29:27]);
      if (idx < nsl(k)) begin
        cs[3'(idx)] = 1'b0;
        rd  = sdata[3'(idx)];
        rdy = srdy[3'(idx)];
      end
    end
    if (err_m[k]) begin
      rd = '0; rdy = 1'b0; be = 1'b1;
    end
  endfunction

  task automatic model_step(input int k);
    logic [3:0] g; logic [29:0] a; logic as_, rw, rdy, be; logic [31:0] wd, rd; logic [7:0] cs;
    int  nown, idx;
    bit  trig, tmo;
    exp_outs(k, g, a, as_, rw, wd, cs, rd, rdy, be);
    idx  = int'(a[29:27]);
    trig = (own[k] >= 0) && !as_ && (idx >= nsl(k));
    nown = own[k];
    if (own[k] < 0 || m_req_[2'(own[k])]) begin
      nown = -1;
      for (int j = 0; j < 4; j++)
        if (nown < 0 && !m_req_[2'((ptr[k] + j) % 4)]) nown = (ptr[k] + j) % 4;
      if (nown >= 0) ptr[k] = (nown + 1) % 4;
    end
    tmo = 1'b0;
`ifdef BUS_TIMEOUT_EN
    tmo = (stall[k] == TO);
    if (!tmo && own[k] >= 0 && nown == own[k] && !as_ && rdy) stall[k]++;
    else stall[k] = 0;
`endif
    err_m[k] = (trig || tmo) && !err_m[k];
    own[k]   = nown;
  endtask

  always @(posedge clk or posedge reset_) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_) begin
        own[k] = -1; ptr[k] = 0; err_m[k] = 1'b0;
`ifdef BUS_TIMEOUT_EN
        stall[k] = 0;
`endif
      end else begin
        model_step(k);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  task automatic compare(input int k, input logic [3:0] g, input logic [29:0] a, input logic as_,
                         input logic rw, input logic [31:0] wd, input logic [7:0] cs,
                         input logic [31:0] rd, input logic rdy, input logic be);
    logic [3:0] eg; logic [29:0] ea; logic eas, erw, erdy, ebe; logic [31:0] ewd, erd; logic [7:0] ecs;
    exp_outs(k, eg, ea, eas, erw, ewd, ecs, erd, erdy, ebe);
    chk($sformatf("m_grnt_[dut%0d]", k), 64'(g), 64'(eg));
    chk($sformatf("s_addr[dut%0d]", k), 64'(a), 64'(ea));
    chk($sformatf("s_as_[dut%0d]", k), 64'(as_), 64'(eas));
    chk($sformatf("s_rw[dut%0d]", k), 64'(rw), 64'(erw));
    chk($sformatf("s_wr_data[dut%0d]", k), 64'(wd), 64'(ewd));
    chk($sformatf("s_cs_[dut%0d]", k), 64'(cs), 64'(ecs));
    chk($sformatf("m_rd_data[dut%0d]", k), 64'(rd), 64'(erd));
    chk($sformatf("m_rdy_[dut%0d]", k), 64'(rdy), 64'(erdy));
    chk($sformatf("bus_err[dut%0d]", k), 64'(be), 64'(ebe));
  endtask

  always @(negedge clk) begin
    compare(0, g8, a8, as8, rw8, wd8, cs8, rd8, rdy8, be8);
    compare(1, g6, a6, as6, rw6, wd6, {2'b11, cs6}, rd6, rdy6, be6);
  end

  // ---------------- directed stimulus; drives and literal checks at negedge+1
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int gi;

  initial begin
    reset_ = 1'b1;
    m_req_ = 4'hF; m_as_ = 4'hF; m_rw = 4'hF; srdy = 8'hFF;
    for (int i = 0; i < 4; i++) begin maddr[i] = '0; mwd[i] = '0; end
    for (int i = 0; i < 8; i++) sdata[i] = {8'(i), 24'h00C0DE};
    repeat (2) step();
    reset_ = 1'b0;
    step();
    chk("rst_grnt", 64'(g8), 64'hF);
    chk("rst_as", 64'(as8), 64'h1);
    chk("rst_addr", 64'(a8), 64'h0);
    chk("rst_cs", 64'(cs8), 64'hFF);
    chk("rst_rdy", 64'(rdy8), 64'h1);
    chk("rst_rd", 64'(rd8), 64'h0);
    chk("rst_err", 64'(be8), 64'h0);

    // single requester, strobe idle
    maddr[0] = 30'h0000_1234;
    m_req_   = 4'b1110;
    #1;
    chk("a_pre_grnt", 64'(g8), 64'hF);
    chk("a_pre_cs", 64'(cs8), 64'hFF);
    step();
    chk("a_grnt", 64'(g8), 64'hE);
    chk("a_addr", 64'(a8), 64'h1234);
    chk("a_as", 64'(as8), 64'h1);
    chk("a_cs", 64'(cs8), 64'hFE);
    m_req_ = 4'hF;
    step();
    chk("a_rel", 64'(g8), 64'hF);

    // all requesting from reset, each releasing after one access
    reset_ = 1'b1;
    step();
    reset_ = 1'b0;
    for (int i = 0; i < 4; i++) maddr[i] = 30'h100 + 30'(i);
    m_as_   = 4'h0;
    srdy[0] = 1'b0;
    m_req_  = 4'h0;
    for (int n = 0; n < 5; n++) begin
      step();
      gi = -1;
      for (int i = 0; i < 4; i++) if (!g8[i]) gi = (gi == -1) ? i : -2;
      chk($sformatf("b_order[%0d]", n), 64'(gi), 64'(exp_order[n]));
      chk($sformatf("b_rdy[%0d]", n), 64'(rdy8), 64'h0);
      m_req_ = 4'h0;
      if (gi >= 0) m_req_[2'(gi)] = 1'b1;
    end
    m_req_ = 4'hF; m_as_ = 4'hF; srdy[0] = 1'b1;
    step();

    // master 1 reads GPIO (slave 4)
    maddr[1] = {3'd4, 27'h10};
    m_as_    = 4'b1101;
    sdata[4] = 32'h0000_00A5;
    srdy[4]  = 1'b0;
    m_req_   = 4'b1101;
    step();
    chk("c_grnt", 64'(g8), 64'hD);
    chk("c_cs", 64'(cs8), 64'hEF);
    chk("c_rdy", 64'(rdy8), 64'h0);
    chk("c_rd", 64'(rd8), 64'hA5);
    chk("c_cs6", 64'(cs6), 64'h2F);
    chk("c_rd6", 64'(rd6), 64'hA5);
    m_req_ = 4'hF; m_as_ = 4'hF; srdy[4] = 1'b1;
    step();
    chk("c_rel_rdy", 64'(rdy8), 64'h1);
    chk("c_rel_rd", 64'(rd8), 64'h0);

    // master 2 writes slave index 7: unmapped on the 6-slave instance
    maddr[2] = {3'd7, 27'h40};
    m_as_    = 4'b1011;
    m_rw[2]  = 1'b0;
    mwd[2]   = 32'hDEAD_BEEF;
    m_req_   = 4'b1011;
    step();
    chk("d_grnt6", 64'(g6), 64'hB);
    chk("d_cs6", 64'(cs6), 64'h3F);
    chk("d_rdy6_0", 64'(rdy6), 64'h1);
    chk("d_err6_0", 64'(be6), 64'h0);
    chk("d_cs8", 64'(cs8), 64'h7F);
    chk("d_wd6", 64'(wd6), 64'hDEAD_BEEF);
    step();
    chk("d_err6_1", 64'(be6), 64'h1);
    chk("d_rdy6_1", 64'(rdy6), 64'h0);
    chk("d_rd6_1", 64'(rd6), 64'h0);
    chk("d_err8_1", 64'(be8), 64'h0);
    step();
    chk("d_err6_2", 64'(be6), 64'h0);
    chk("d_rdy6_2", 64'(rdy6), 64'h1);
    step();
    chk("d_err6_3", 64'(be6), 64'h1);
    chk("d_rdy6_3", 64'(rdy6), 64'h0);
    m_req_ = 4'hF; m_as_ = 4'hF; m_rw = 4'hF;
    step();
    chk("d_err6_rel", 64'(be6), 64'h0);

    // master 3 stalls on slave 5
    maddr[3] = {3'd5, 27'h0};
    m_as_    = 4'b0111;
    m_req_   = 4'b0111;
    step();
    chk("e_grnt", 64'(g8), 64'h7);
    for (int c = 1; c <= TO; c++) begin
      step();
      chk($sformatf("e_rdy_t%0d", c), 64'(rdy8), 64'h1);
      chk($sformatf("e_err_t%0d", c), 64'(be8), 64'h0);
    end
    step();
`ifdef BUS_TIMEOUT_EN
    chk("e_to_rdy", 64'(rdy8), 64'h0);
    chk("e_to_err", 64'(be8), 64'h1);
    chk("e_to_rd", 64'(rd8), 64'h0);
    chk("e_to_err6", 64'(be6), 64'h1);
`else
    chk("e_stall_rdy", 64'(rdy8), 64'h1);
    chk("e_stall_err", 64'(be8), 64'h0);
`endif
    step();
    chk("e_after_err", 64'(be8), 64'h0);
    m_req_ = 4'hF; m_as_ = 4'hF;
    step();

    // reset while master 2 is mid-access; pointer must restart at 0
    maddr[2] = 30'h200;
    m_as_    = 4'b1011;
    m_req_   = 4'b1011;
    step();
    chk("f_grnt", 64'(g8), 64'hB);
    #2;
    reset_ = 1'b1;
    #1;
    chk("f_rst_grnt", 64'(g8), 64'hF);
    chk("f_rst_as", 64'(as8), 64'h1);
    chk("f_rst_cs", 64'(cs8), 64'hFF);
    chk("f_rst_rdy", 64'(rdy8), 64'h1);
    m_req_ = 4'b0110;
    m_as_  = 4'hF;
    step();
    reset_ = 1'b0;
    step();
    chk("f_ptr0", 64'(g8), 64'hE);
    m_req_ = 4'hF;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
